// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline definitions: datapath width, bubble encoding,
// fetch FSM encoding and the IF/ID register layout.
package rv32_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_DROP  = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
    logic            valid;
  } ifid_t;

  // Instruction fetches are word aligned, so redirect targets lose their low bits.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & {{(XLEN-2){1'b1}}, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response port of the fetch stage.
interface fetch_stage_if;
  import rv32_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, output imem_addr, input imem_rvalid, input imem_rdata);
  modport slave  (input imem_req, input imem_addr, output imem_rvalid, output imem_rdata);

endinterface

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: flush beats the enable; an enabled cycle with
// nothing delivered loads a bubble that keeps the previous pc.
module ifid_reg #(
  parameter logic [rv32_pkg::XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            flush,
  input  logic            load,
  input  rv32_pkg::ifid_t d,
  output rv32_pkg::ifid_t q
);
  import rv32_pkg::*;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
    end else if (flush) begin
      q <= '{pc: q.pc, instr: NOP_INSTR, valid: 1'b0};
    end else if (en) begin
      q <= load ? d : '{pc: q.pc, instr: NOP_INSTR, valid: 1'b0};
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: PC, single-outstanding imem request FSM,
// stall holding buffer and the IF/ID register feeding decode.
module fetch_stage #(
  parameter logic [rv32_pkg::XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [rv32_pkg::XLEN-1:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      pc_write,
  input  logic                      ifid_write,
  input  logic                      flush,
  input  logic [rv32_pkg::XLEN-1:0] redirect_pc,
  fetch_stage_if.master             imem,
  output logic [rv32_pkg::XLEN-1:0] ifid_pc,
  output logic [rv32_pkg::XLEN-1:0] ifid_instr,
  output logic                      ifid_valid
);
  import rv32_pkg::*;

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt, pc_plus4, redirect_aligned, hold_buf;
  logic            advance, deliver, hold_load;
  ifid_t           ifid_d, ifid_q;

  assign advance          = pc_write & ifid_write & ~flush;
  assign pc_plus4         = pc + 32'd4;
  assign redirect_aligned = align_word(redirect_pc);

  // NOTE: every signal gets a default before the case; a branch that forgot one would infer a latch.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    deliver        = 1'b0;
    hold_load      = 1'b0;
    imem.imem_req  = 1'b0;
    imem.imem_addr = pc;
    case (state)
      S_BOOT: state_nxt = S_ISSUE;
      S_ISSUE: begin
        if (flush) begin
          pc_nxt = redirect_aligned;
        end else begin
          imem.imem_req = 1'b1;
          state_nxt     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (flush) begin
            pc_nxt    = redirect_aligned;
            state_nxt = S_ISSUE;
          end else if (advance) begin
            // Response consumed this cycle, so the next request overlaps it.
            deliver        = 1'b1;
            pc_nxt         = pc_plus4;
            imem.imem_req  = 1'b1;
            imem.imem_addr = pc_plus4;
          end else begin
            hold_load = 1'b1;
            state_nxt = S_HOLD;
          end
        end else if (flush) begin
          pc_nxt    = redirect_aligned;
          state_nxt = S_DROP;
        end
      end
      S_HOLD: begin
        if (flush) begin
          pc_nxt    = redirect_aligned;
          state_nxt = S_ISSUE;
        end else if (advance) begin
          deliver        = 1'b1;
          pc_nxt         = pc_plus4;
          imem.imem_req  = 1'b1;
          imem.imem_addr = pc_plus4;
          state_nxt      = S_WAIT;
        end
      end
      S_DROP: begin
        // The stale response must drain before the redirect target is requested.
        if (flush)            pc_nxt    = redirect_aligned;
        if (imem.imem_rvalid) state_nxt = S_ISSUE;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_BOOT;
      pc       <= RESET_PC;
      hold_buf <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (hold_load) hold_buf <= imem.imem_rdata;
    end
  end

  assign ifid_d = '{pc:    pc,
                    instr: (state == S_HOLD) ? hold_buf : imem.imem_rdata,
                    valid: 1'b1};

  ifid_reg #(.NOP_INSTR(NOP_INSTR)) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (ifid_write),
    .flush (flush),
    .load  (deliver),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  assign ifid_pc    = ifid_q.pc;
  assign ifid_instr = ifid_q.instr;
  assign ifid_valid = ifid_q.valid;

endmodule
